axis_pkt_framer: RTL and testbench
==================================

# axis_pkt_framer

Stream framer downstream of the data-route 128-bit output ports (out_d / out_e), before the DMA S2MM write channel. It accepts an unframed 128-bit AXI-Stream and emits packets of exactly cfg_pkt_len beats, cfg_pkt_num packets per job. Each packet's final beat carries tlast, and tkeep is all ones. A two-entry skid buffer gives full throughput with registered outputs.

## Interface
- DWIDTH, 128, data width in bits; multiple of 8.
- LEN_W, 16, width of the packet-length and packet-count fields.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cfg_start  in  1  one-cycle pulse; launches a job; honoured in IDLE only.
- cfg_pkt_len  in  LEN_W  beats per packet; sampled on cfg_start.
- cfg_pkt_num  in  LEN_W  packets per job; sampled on cfg_start.
- s_axis_tdata  in  DWIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DWIDTH  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tkeep  out  DWIDTH/8  byte enables; constant all ones.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high from accepted cfg_start until the done cycle.
- done  out  1  one-cycle pulse when the final beat of the job handshakes on the output.
- cfg_err  out  1  sticky; set when cfg_start arrives with len=0 or num=0; cleared by the next valid cfg_start.

## Operation
- **IDLE state.**
  - s_axis_tready=0.
  - On cfg_start with len≠0 and num≠0: latch len/num, clear counters, go to RUN, busy=1.
  - On cfg_start with len=0 or num=0: set cfg_err and stay in IDLE.
- **RUN state.**
  - Input handshake (s_tvalid & s_tready) writes {tdata, tag_last} into the skid buffer.
  - tag_last = (beat_cnt == len-1).
  - beat_cnt increments per accepted beat and wraps to 0 after len-1. pkt_cnt increments on each wrap.
  - After the beat with beat_cnt=len-1 and pkt_cnt=num-1 is accepted, go to DRAIN.
- **DRAIN state.**
  - s_axis_tready=0.
  - The buffer empties to the output.
  - When the last-tagged final beat handshakes on the output: done=1 for that cycle, busy=0, next state IDLE.
- cfg_start in RUN or DRAIN is ignored: no latch, no cfg_err change.
- **Skid buffer.** Two entries, main (drives m_axis_*) and skid.
  - s_axis_tready = RUN & ~skid_full. This is a registered signal with no combinational path from m_axis_tready.
  - Output pops main when m_tvalid & m_tready. Skid moves into main on the same edge.
  - Simultaneous push and pop with main occupied and skid empty: new data goes to main.
- Data and tlast are never altered; no beats are dropped or duplicated.
- Counters are LEN_W bits. len and num of 2^LEN_W-1 are legal; no overflow is possible because counters stop at len-1 and num-1.

## Timing
- **Reset values.** All of these hold while rst_n=0 and are applied asynchronously on assertion:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - m_axis_tkeep=all ones.
  - s_axis_tready=0, busy=0, done=0, cfg_err=0.
  - state=IDLE, buffer empty.
- **Reset mid-job.** In-flight beats are discarded. After rst_n rises, the block waits for a new cfg_start.
- **Start.** cfg_start at edge N puts busy=1 and s_axis_tready=1 after edge N. The first input beat can be accepted at edge N+1.
- **Latency.** Input accept to m_axis_tvalid is 1 cycle when the buffer is empty.
- **Throughput.** With s_tvalid=1 and m_tready=1 held, 1 beat per cycle, with no bubbles at packet boundaries.
- **Backpressure.**
  - m_tready low for k≥2 cycles: at most 2 beats are stored, then s_tready=0 from the cycle after the skid fills.
  - When m_tready returns, s_tready re-asserts 1 cycle after the first pop.
- **AXI-Stream rules.** While m_tvalid=1 and m_tready=0, tdata and tlast hold stable. m_tvalid never drops without a handshake.
- **done timing.** done is asserted in the cycle following the final output handshake edge, for exactly 1 cycle. busy falls in that same cycle.

## Test plan
- **Basic job.** len=4, num=3, 12 incrementing beats, m_tready=1 → tlast on beats 3, 7, 11; tkeep=0xffff; done pulse 1 cycle after beat 11 handshakes; s_tready=0 after beat 11 is accepted.
- **Random backpressure.** len=5, num=4, random m_tready (50%) and s_tvalid (70%) → 20 beats in order, tlast every 5th, no data changes while stalled, s_tready never high with both entries full.
- **Length-1 edge case.** len=1, num=1 → single beat with tlast=1, done; then len=0 start → cfg_err=1, state stays IDLE, s_tready stays 0.
- **Ignored restart.** cfg_start pulsed during RUN with len=2 → ignored; the original len=4 framing continues.
- **Reset mid-job.** rst_n low after 6 of 12 beats → m_tvalid=0, busy=0 immediately; a new job len=2, num=2 then completes with correct tlast.
- **Full throughput.** len=8, num=16, continuous valid/ready → 128 beats in 128 consecutive cycles after the first output beat.

Source files
------------

// File: rtl/axis_pkt_framer.sv
// Frames an unbounded 128-bit AXI-Stream into cfg_pkt_num packets of cfg_pkt_len beats each.
// A two-entry main/skid buffer keeps every output and s_axis_tready registered.
module axis_pkt_framer #(
  parameter int DWIDTH = 128,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [LEN_W-1:0]      cfg_pkt_len,
  input  logic [LEN_W-1:0]      cfg_pkt_num,
  input  logic [DWIDTH-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DWIDTH/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, num_q, num_d;
  logic [LEN_W-1:0]   beat_q, beat_d, pkt_q, pkt_d;
  logic               main_vld_q, main_vld_d, main_last_q, main_last_d;
  logic [DWIDTH-1:0]  main_data_q, main_data_d;
  logic               skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DWIDTH-1:0]  skid_data_q, skid_data_d;
  logic               s_rdy_q, s_rdy_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               push, pop, tag_last;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    num_d       = num_q;
    beat_d      = beat_q;
    pkt_d       = pkt_q;
    main_vld_d  = main_vld_q;
    main_last_d = main_last_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    busy_d      = busy_q;
    err_d       = err_q;
    done_d      = 1'b0;

    // s_rdy_q already implies RUN and an empty skid slot
    push     = s_axis_tvalid & s_rdy_q;
    pop      = main_vld_q & m_axis_tready;
    tag_last = (beat_q == len_q - LEN_W'(1));

    if (pop) begin
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        main_last_d = skid_last_q;
        skid_vld_d  = push;
        skid_data_d = s_axis_tdata;
        skid_last_d = tag_last;
        if (!push) skid_vld_d = 1'b0;
      end else begin
        main_vld_d  = push;
        main_data_d = push ? s_axis_tdata : main_data_q;
        main_last_d = push ? tag_last : main_last_q;
      end
    end else if (push) begin
      if (!main_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = s_axis_tdata;
        main_last_d = tag_last;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = s_axis_tdata;
        skid_last_d = tag_last;
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_pkt_len != '0 && cfg_pkt_num != '0) begin
            len_d   = cfg_pkt_len;
            num_d   = cfg_pkt_num;
            beat_d  = '0;
            pkt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (push) begin
          if (tag_last) begin
            beat_d = '0;
            pkt_d  = pkt_q + LEN_W'(1);
            if (pkt_q == num_q - LEN_W'(1)) state_d = DRAIN;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        // no pushes here, so a pop with skid empty is the job's final beat leaving
        if (pop && !skid_vld_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    s_rdy_d = (state_d == RUN) & ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      num_q       <= '0;
      beat_q      <= '0;
      pkt_q       <= '0;
      main_vld_q  <= 1'b0;
      main_last_q <= 1'b0;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      s_rdy_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      num_q       <= num_d;
      beat_q      <= beat_d;
      pkt_q       <= pkt_d;
      main_vld_q  <= main_vld_d;
      main_last_q <= main_last_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
      s_rdy_q     <= s_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tdata  = main_data_q;
  assign m_axis_tvalid = main_vld_q;
  assign m_axis_tlast  = main_last_q;
  assign m_axis_tkeep  = '1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = err_q;
endmodule

// File: tb/tb_axis_pkt_framer.sv
// Randomized bench for axis_pkt_framer: a queue-based job model predicts every output each cycle.
module tb_axis_pkt_framer;
  localparam int DW = 128;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic [LW-1:0]   cfg_pkt_len = '0, cfg_pkt_num = '0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic [DW/8-1:0] m_axis_tkeep;
  logic            m_axis_tlast;
  logic            busy, done, cfg_err;

  always #5 clk = ~clk;

  axis_pkt_framer #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_pkt_len(cfg_pkt_len),
    .cfg_pkt_num(cfg_pkt_num), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;

  // job model: beats accepted so far decide tlast by position; occupancy = in - out
  beat_t       q[$];
  bit          active = 0, err_m = 0, done_pend = 0, prev_stall = 0;
  int          len_m = 1, num_m = 1, acc = 0, outs = 0, occ = 0, jobs_done = 0, cyc = 0;
  int          first_out_cyc = 0, last_out_cyc = 0;
  int          last_idx[$];
  logic [DW-1:0] prev_d;
  logic        prev_l;

  always @(negedge clk) begin
    bit was_active;
    beat_t b;
    cyc++;
    if (!rst_n) begin
      q.delete();
      active = 0; err_m = 0; done_pend = 0; prev_stall = 0; occ = 0; acc = 0; outs = 0;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tkeep", m_axis_tkeep, {(DW/8){1'b1}});
    end else begin
      chk("m_tvalid", m_axis_tvalid, occ > 0);
      chk("s_tready", s_axis_tready, active && acc < len_m * num_m && occ < 2);
      chk("busy", busy, active);
      chk("done", done, done_pend);
      chk("cfg_err", cfg_err, err_m);
      chk("tkeep", m_axis_tkeep, {(DW/8){1'b1}});
      if (prev_stall) begin
        chk("hold_tvalid", m_axis_tvalid, 1);
        chk("hold_tdata", m_axis_tdata, prev_d);
        chk("hold_tlast", m_axis_tlast, prev_l);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;

      was_active = active;
      done_pend = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          b = q.pop_front();
          chk("out_tdata", m_axis_tdata, b.d);
          chk("out_tlast", m_axis_tlast, b.l);
        end
        if (m_axis_tlast) last_idx.push_back(outs);
        if (outs == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        outs++;
        occ--;
        if (active && outs == len_m * num_m) begin
          active = 0; done_pend = 1; jobs_done++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        q.push_back({s_axis_tdata, (acc % len_m) == len_m - 1});
        acc++;
        occ++;
      end
      if (cfg_start && !was_active) begin
        if (cfg_pkt_len != 0 && cfg_pkt_num != 0) begin
          active = 1; len_m = cfg_pkt_len; num_m = cfg_pkt_num;
          acc = 0; outs = 0; err_m = 0; last_idx.delete();
        end else err_m = 1;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0; cfg_start = 1'b0; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // restart_at: cycle index of a stray cfg_start (len=2); reset_after: beats before reset (0 = none)
  task automatic run_job(input int len, input int num, input int vp, input int rp,
                         input int restart_at, input int reset_after);
    int base;
    base = jobs_done;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_pkt_len = LW'(len); cfg_pkt_num = LW'(num);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int t = 0; t < 5000 && jobs_done == base; t++) begin
      s_axis_tvalid = ($urandom_range(99) < vp);
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      m_axis_tready = ($urandom_range(99) < rp);
      if (t == restart_at) begin
        cfg_start = 1'b1; cfg_pkt_len = LW'(2); cfg_pkt_num = LW'(1);
      end else cfg_start = 1'b0;
      if (reset_after > 0 && acc >= reset_after) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", m_axis_tvalid, 0);
        chk("async_rst_busy", busy, 0);
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    if (jobs_done == base) begin
      chk("job_timeout", 0, 1);
      do_reset();
    end
    s_axis_tvalid = 1'b0; cfg_start = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic job: tlast on beats 3, 7, 11
    run_job(4, 3, 100, 100, -1, 0);
    chk("basic_tlast_cnt", last_idx.size(), 3);
    if (last_idx.size() == 3) begin
      chk("basic_tlast0", last_idx[0], 3);
      chk("basic_tlast1", last_idx[1], 7);
      chk("basic_tlast2", last_idx[2], 11);
    end

    // random backpressure
    run_job(5, 4, 70, 50, -1, 0);
    chk("bp_beats", outs, 20);
    chk("bp_tlast_cnt", last_idx.size(), 4);

    // length-1 job, then an illegal start
    run_job(1, 1, 100, 100, -1, 0);
    chk("len1_tlast_cnt", last_idx.size(), 1);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_pkt_len = '0; cfg_pkt_num = LW'(3);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(posedge clk); #1;
    chk("len0_err", cfg_err, 1);
    chk("len0_tready", s_axis_tready, 0);
    chk("len0_busy", busy, 0);

    // stray start during RUN must not change len=4 framing
    run_job(4, 3, 80, 80, 3, 0);
    chk("restart_tlast_cnt", last_idx.size(), 3);
    if (last_idx.size() == 3) chk("restart_tlast2", last_idx[2], 11);

    // reset after 6 of 12 beats, then a fresh job
    run_job(4, 3, 100, 60, -1, 6);
    run_job(2, 2, 90, 90, -1, 0);
    chk("post_rst_tlast_cnt", last_idx.size(), 2);
    if (last_idx.size() == 2) begin
      chk("post_rst_tlast0", last_idx[0], 1);
      chk("post_rst_tlast1", last_idx[1], 3);
    end

    // full throughput: 128 beats back to back
    run_job(8, 16, 100, 100, -1, 0);
    chk("tp_beats", outs, 128);
    chk("tp_span", last_out_cyc - first_out_cyc, 127);

    // a few more random jobs
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(30, 100),
              $urandom_range(30, 100), -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
